// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - word stream in and instruction memory write port of the loader
interface imem_loader_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams LEN/BASE/payload/CHK into instruction memory, holds the cpu until verified
module imem_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_hold,
  output logic [15:0]   word_count
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HDR_LEN  = 3'd1;
  localparam logic [2:0] HDR_BASE = 3'd2;
  localparam logic [2:0] PAYLOAD  = 3'd3;
  localparam logic [2:0] CHECK    = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] ERR      = 3'd6;

  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state;
  logic [15:0] lenReg;
  logic [15:0] ptr;
  logic [15:0] runXor;
  logic [15:0] idleCnt;
  logic [15:0] wordCount;
  logic        memWe;
  logic [15:0] memAddr;
  logic [15:0] memWdata;
  logic        loading;
  logic        accept;

  assign loading = (state == HDR_LEN) || (state == HDR_BASE) ||
                   (state == PAYLOAD) || (state == CHECK);
  assign accept  = bus.in_valid & loading;

  assign bus.in_ready  = loading;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign busy          = loading;
  assign done          = (state == DONE);
  assign error         = (state == ERR);
  assign cpu_hold      = (state != DONE);
  assign word_count    = wordCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lenReg    <= '0;
      ptr       <= '0;
      runXor    <= '0;
      idleCnt   <= '0;
      wordCount <= '0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWdata  <= '0;
    end else begin
      memWe <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= HDR_LEN;
            wordCount <= '0;
            runXor    <= '0;
            idleCnt   <= '0;
          end
        end
        HDR_LEN, HDR_BASE, PAYLOAD, CHECK: begin
          // any valid cycle resets the idle run, accepted or not
          if (bus.in_valid) begin
            idleCnt <= '0;
          end else if (idleCnt == IDLE_LAST) begin
            state <= ERR;
          end else begin
            idleCnt <= idleCnt + 16'd1;
          end

          if (accept) begin
            case (state)
              HDR_LEN: begin
                lenReg <= bus.in_data;
                state  <= HDR_BASE;
              end
              HDR_BASE: begin
                ptr   <= bus.in_data;
                state <= (lenReg != 16'd0) ? PAYLOAD : CHECK;
              end
              PAYLOAD: begin
                memWe     <= 1'b1;
                memAddr   <= ptr;
                memWdata  <= bus.in_data;
                ptr       <= ptr + 16'd1;
                wordCount <= wordCount + 16'd1;
                runXor    <= runXor ^ bus.in_data;
                if (wordCount == lenReg - 16'd1) begin
                  state <= CHECK;
                end
              end
              CHECK: begin
                state <= (bus.in_data == runXor) ? DONE : ERR;
              end
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized and directed load streams checked against a stream-level model
module tb_imem_loader;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error, cpu_hold;
  logic [15:0] word_count;

  imem_loader_if ifc ();

  imem_loader #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .start(start), .bus(ifc),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
    .word_count(word_count)
  );

  always #5 clock = ~clock;

  int          nTests = 0;
  int          nFail  = 0;
  logic [15:0] stream[$];
  logic [15:0] obsAddr[$];
  logic [15:0] obsData[$];
  longint      obsTime[$];
  longint      accTime[$];
  longint      lastEdge;

  always @(posedge clock) begin
    #1;
    if (ifc.mem_we === 1'b1) begin
      obsAddr.push_back(ifc.mem_addr);
      obsData.push_back(ifc.mem_wdata);
      obsTime.push_back(longint'($time) - 1);
    end
  end

  task automatic expectEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stepClk();
    @(posedge clock);
    lastEdge = longint'($time);
    #1;
  endtask

  task automatic clearObs();
    obsAddr.delete();
    obsData.delete();
    obsTime.delete();
    accTime.delete();
  endtask

  task automatic sendWord(input logic [15:0] w, input int gap, input bit poke, output longint t);
    bit got;
    bit rdy;
    got = 1'b0;
    t = 0;
    ifc.in_valid = 1'b0;
    repeat (gap) stepClk();
    ifc.in_valid = 1'b1;
    ifc.in_data  = w;
    start        = poke;
    for (int k = 0; k < 8 && !got; k++) begin
      rdy = ifc.in_ready;
      stepClk();
      if (rdy) begin
        got = 1'b1;
        t = lastEdge;
      end
    end
    ifc.in_valid = 1'b0;
    start        = 1'b0;
    if (!got) expectEq("acceptBound", 0, 1);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    stepClk();
    start = 1'b0;
  endtask

  task automatic runLoad(input string tag, input int gapMax, input bit poke);
    logic [15:0] n, base, chkWord, x, a;
    longint      t;
    int          g;
    bit          p;
    n       = stream[0];
    base    = stream[1];
    chkWord = stream[stream.size() - 1];
    x       = '0;
    for (int i = 0; i < int'(n); i++) x ^= stream[i + 2];
    clearObs();
    pulseStart();
    expectEq({tag, ".busyAfterStart"}, busy, 1);
    for (int i = 0; i < stream.size(); i++) begin
      g = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      p = poke && (i >= 2) && ($urandom_range(0, 2) == 0);
      sendWord(stream[i], g, p, t);
      if (i >= 2 && i < int'(n) + 2) accTime.push_back(t);
    end
    expectEq({tag, ".writeCount"}, obsAddr.size(), n);
    for (int i = 0; i < int'(n) && i < obsAddr.size(); i++) begin
      a = base + 16'(i);
      expectEq({tag, ".addr"}, obsAddr[i], a);
      expectEq({tag, ".data"}, obsData[i], stream[i + 2]);
      expectEq({tag, ".writeCycle"}, obsTime[i], accTime[i]);
    end
    expectEq({tag, ".done"}, done, chkWord == x);
    expectEq({tag, ".error"}, error, chkWord != x);
    expectEq({tag, ".cpuHold"}, cpu_hold, chkWord != x);
    expectEq({tag, ".busyEnd"}, busy, 0);
    expectEq({tag, ".wordCount"}, word_count, n);
  endtask

  initial begin
    longint      t;
    logic [15:0] n, x;
    ifc.in_valid = 1'b0;
    ifc.in_data  = '0;

    #3 reset = 1'b0;
    stepClk();
    stepClk();
    expectEq("rst.inReady", ifc.in_ready, 0);
    expectEq("rst.memWe", ifc.mem_we, 0);
    expectEq("rst.memAddr", ifc.mem_addr, 0);
    expectEq("rst.memWdata", ifc.mem_wdata, 0);
    expectEq("rst.busy", busy, 0);
    expectEq("rst.done", done, 0);
    expectEq("rst.error", error, 0);
    expectEq("rst.cpuHold", cpu_hold, 1);
    expectEq("rst.wordCount", word_count, 0);
    #2 reset = 1'b1;
    stepClk();

    stream = '{16'd3, 16'h0010, 16'h1234, 16'h00FF, 16'hF000, 16'hE2CB};
    runLoad("good", 0, 0);
    stream = '{16'd3, 16'h0010, 16'h1234, 16'h00FF, 16'hF000, 16'h0000};
    runLoad("badChk", 0, 0);
    stream = '{16'd2, 16'hFFFF, 16'hAAAA, 16'h5555, 16'hFFFF};
    runLoad("wrap", 0, 0);
    stream = '{16'd0, 16'h0100, 16'h0000};
    runLoad("empty", 0, 0);

    // start together with a valid word while DONE: start wins, word dropped
    ifc.in_valid = 1'b1;
    ifc.in_data  = 16'h0007;
    start        = 1'b1;
    stepClk();
    start        = 1'b0;
    ifc.in_valid = 1'b0;
    expectEq("startInDone.busy", busy, 1);
    expectEq("startInDone.done", done, 0);
    expectEq("startInDone.wordCount", word_count, 0);
    stream = '{16'd1, 16'h0300, 16'h0042, 16'h0042};
    runLoad("afterStartInDone", 0, 0);

    clearObs();
    pulseStart();
    sendWord(16'd5, 0, 0, t);
    repeat (3) stepClk();
    expectEq("timeout.before", error, 0);
    stepClk();
    expectEq("timeout.error", error, 1);
    expectEq("timeout.done", done, 0);
    expectEq("timeout.cpuHold", cpu_hold, 1);
    expectEq("timeout.busy", busy, 0);

    clearObs();
    pulseStart();
    sendWord(16'd3, 0, 0, t);
    sendWord(16'h0200, 0, 0, t);
    sendWord(16'hBEEF, 0, 0, t);
    #2 reset = 1'b0;
    #1;
    expectEq("midRst.busy", busy, 0);
    expectEq("midRst.memWe", ifc.mem_we, 0);
    expectEq("midRst.inReady", ifc.in_ready, 0);
    expectEq("midRst.cpuHold", cpu_hold, 1);
    expectEq("midRst.wordCount", word_count, 0);
    expectEq("midRst.partialWrites", obsAddr.size(), 1);
    stepClk();
    #2 reset = 1'b1;
    stepClk();
    stream = '{16'd3, 16'h0200, 16'hBEEF, 16'h1111, 16'h2222, 16'hBEEF ^ 16'h1111 ^ 16'h2222};
    runLoad("reload", 0, 0);

    for (int r = 0; r < 10; r++) begin
      n = 16'($urandom_range(0, 6));
      stream.delete();
      stream.push_back(n);
      stream.push_back(16'($urandom));
      x = '0;
      for (int i = 0; i < int'(n); i++) begin
        stream.push_back(16'($urandom));
        x ^= stream[i + 2];
      end
      if ($urandom_range(0, 2) == 0) x ^= 16'($urandom_range(1, 16'hFFFF));
      stream.push_back(x);
      runLoad($sformatf("rand%0d", r), 2, 1);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
